// File: rtl/ctl_pkg.sv
// Shared definitions for the multicycle control unit: opcode constants,
// FSM state encoding and the datapath select encodings.
package ctl_pkg;

  // Opcodes decoded in DECODE (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // alu_op encodings sent to the ALU control unit
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // alu_src_b encodings
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // pc_source encodings
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // FETCH is encoded as zero so the debug state port reads FETCH in reset
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9
  } state_t;

endpackage

// File: rtl/multicycle_control_unit.sv
// Moore-style control FSM for a classic multicycle MIPS datapath.
// Optional build macro MEM_WAIT_EN: FETCH, MEM_READ and MEM_WRITE stall
// until mem_ready=1; otherwise mem_ready is ignored.
module multicycle_control_unit
  import ctl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;
  logic   ready;

`ifdef MEM_WAIT_EN
  assign ready = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign ready            = 1'b1;
`endif

  // State register with synchronous active-low reset
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state and output decode from the current state; reset forces all outputs low
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_op        = ALU_ADD;
    alu_src_b     = SRCB_REG;
    pc_source     = PCSRC_ALU;
    illegal_op    = 1'b0;
    state         = state_q;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = ready;
        pc_write  = ready;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        pc_source = PCSRC_ALU;
        state_d   = ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu_op    = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
        state_d   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        state_d   = ready ? S_FETCH : S_MEM_WRITE;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_op    = ALU_FUNCT;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (!rst_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      alu_src_a     = 1'b0;
      alu_op        = 2'b00;
      alu_src_b     = 2'b00;
      pc_source     = 2'b00;
      illegal_op    = 1'b0;
      state         = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit. Expected per-cycle
// output vectors are queued when an instruction is issued and compared on
// the falling edge as the FSM steps through it.
module tb_multicycle_control_unit;
  import ctl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, reg_dst, alu_src_a, illegal_op;
  logic [1:0] alu_op, alu_src_b, pc_source;
  logic [3:0] state;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  typedef struct {
    string       tag;
    logic [20:0] v;
  } exp_t;

  exp_t exp_q[$];

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .reg_dst(reg_dst),
    .alu_src_a(alu_src_a), .alu_op(alu_op), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Packed view of every DUT output
  function automatic logic [20:0] obs();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
            mem_to_reg, reg_write, reg_dst, alu_src_a, alu_op, alu_src_b,
            pc_source, illegal_op, state};
  endfunction

  // Expected output vector for a state, from the control table
  function automatic logic [20:0] ev(input state_t st, input bit ill = 1'b0,
                                     input bit rdy = 1'b1);
    logic pw, pwc, iod, mr, mw, irw, m2r, rw, rd, asa;
    logic [1:0] aop, bsrc, psrc;
    {pw, pwc, iod, mr, mw, irw, m2r, rw, rd, asa} = '0;
    aop = 2'b00; bsrc = 2'b00; psrc = 2'b00;
    case (st)
      S_FETCH:     begin mr = 1; irw = rdy; pw = rdy; bsrc = 2'b01; end
      S_DECODE:    bsrc = 2'b11;
      S_MEM_ADDR:  begin asa = 1; bsrc = 2'b10; end
      S_MEM_READ:  begin mr = 1; iod = 1; end
      S_MEM_WB:    begin rw = 1; m2r = 1; end
      S_MEM_WRITE: begin mw = 1; iod = 1; end
      S_EXECUTE:   begin asa = 1; aop = 2'b10; end
      S_R_WB:      begin rw = 1; rd = 1; end
      S_BRANCH:    begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      S_JUMP:      begin pw = 1; psrc = 2'b10; end
      default:     ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rw, rd, asa, aop, bsrc, psrc,
            ill, 4'(st)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic push(input string tag, input logic [20:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  // Compare the current cycle against the head of the queue, then advance
  task automatic step();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("queue_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, 32'(obs()), 32'(e.v));
    end
    @(negedge clk);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) step();
  endtask

  // Issue one instruction from FETCH and check every cycle until the next FETCH
  task automatic run_instr(input logic [5:0] op, input string name);
    opcode = op;
    push({name, "_fetch"}, ev(S_FETCH));
    case (op)
      OP_LW: begin
        push({name, "_dec"}, ev(S_DECODE));
        push({name, "_addr"}, ev(S_MEM_ADDR));
        push({name, "_rd"}, ev(S_MEM_READ));
        push({name, "_wb"}, ev(S_MEM_WB));
      end
      OP_SW: begin
        push({name, "_dec"}, ev(S_DECODE));
        push({name, "_addr"}, ev(S_MEM_ADDR));
        push({name, "_wr"}, ev(S_MEM_WRITE));
      end
      OP_RTYPE: begin
        push({name, "_dec"}, ev(S_DECODE));
        push({name, "_exe"}, ev(S_EXECUTE));
        push({name, "_wb"}, ev(S_R_WB));
      end
      OP_BEQ: begin
        push({name, "_dec"}, ev(S_DECODE));
        push({name, "_br"}, ev(S_BRANCH));
      end
      OP_J: begin
        push({name, "_dec"}, ev(S_DECODE));
        push({name, "_jmp"}, ev(S_JUMP));
      end
      default: push({name, "_dec_ill"}, ev(S_DECODE, 1'b1));
    endcase
    drain();
  endtask

  initial begin
    int start;
    logic [5:0] bad_ops [4];
    bad_ops = '{6'b111111, 6'b000001, 6'b001000, 6'b100000};

    rst_n = 1'b0;
    opcode = OP_RTYPE;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold", 32'(obs()), 32'd0);
    rst_n = 1'b1;
    #1;
    check("reset_release_fetch", 32'(obs()), 32'(ev(S_FETCH)));

    run_instr(OP_LW, "lw");

`ifndef MEM_WAIT_EN
    // mem_ready has no effect in the default build
    mem_ready = 1'b0;
`endif
    run_instr(OP_SW, "sw");
    mem_ready = 1'b1;

    start = cyc;
    run_instr(OP_RTYPE, "r");
    run_instr(OP_BEQ, "beq");
    check("r_beq_cycles", 32'(cyc - start), 32'd7);

    start = cyc;
    run_instr(OP_J, "j");
    check("j_cycles", 32'(cyc - start), 32'd3);

    foreach (bad_ops[i]) begin
      start = cyc;
      run_instr(bad_ops[i], $sformatf("ill%0d", i));
      check($sformatf("ill%0d_cycles", i), 32'(cyc - start), 32'd2);
    end

    // Reset held for three edges in the middle of EXECUTE
    opcode = OP_RTYPE;
    push("rst_fetch", ev(S_FETCH));
    push("rst_dec", ev(S_DECODE));
    drain();
    check("rst_pre_exe", 32'(obs()), 32'(ev(S_EXECUTE)));
    rst_n = 1'b0;
    #1;
    check("rst_mid_exe", 32'(obs()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_hold%0d", i), 32'(obs()), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    check("rst_after_fetch", 32'(obs()), 32'(ev(S_FETCH)));
    run_instr(OP_RTYPE, "r_after_rst");

`ifdef MEM_WAIT_EN
    // SW with three not-ready cycles in MEM_WRITE
    opcode = OP_SW;
    push("wsw_fetch", ev(S_FETCH));
    push("wsw_dec", ev(S_DECODE));
    step();
    step();
    push("wsw_addr", ev(S_MEM_ADDR));
    exp_q[0].tag = "wsw_addr";
    begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.tag, 32'(obs()), 32'(e.v));
    end
    mem_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wsw_wr%0d", i), 32'(obs()), 32'(ev(S_MEM_WRITE)));
      if (i == 3) mem_ready = 1'b1;
      @(negedge clk);
    end
    check("wsw_back_fetch", 32'(obs()), 32'(ev(S_FETCH)));

    // FETCH stall: strobes low until memory is ready
    mem_ready = 1'b0;
    #1;
    check("wfetch_stall", 32'(obs()), 32'(ev(S_FETCH, 1'b0, 1'b0)));
    @(negedge clk);
    check("wfetch_still", 32'(obs()), 32'(ev(S_FETCH, 1'b0, 1'b0)));
    mem_ready = 1'b1;
    #1;
    check("wfetch_ready", 32'(obs()), 32'(ev(S_FETCH)));
    @(negedge clk);
    check("wfetch_dec", 32'(obs()), 32'(ev(S_DECODE)));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-003 opcode  input  6  instruction[31:26], held stable by the instruction register after FETCH.
REQ-004 mem_ready  input  1  memory access complete; used only when MEM_WAIT_EN is defined.
REQ-005 pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a  output  1 each  datapath strobes/selects.
REQ-006 alu_op  output  2  to the ALU control unit: 00 add, 01 subtract, 10 use funct.
REQ-007 alu_src_b  output  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-008 pc_source  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-009 illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-010 state  output  4  current FSM state encoding, for debug and the bench.

Function
REQ-011 Moore FSM; all outputs SHALL decode from the current state only, except illegal_op.
REQ-012 States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, R_WB, BRANCH, JUMP.
REQ-013 FETCH: mem_read=1, ir_write=1, alu_src_b=01, alu_op=00, pc_write=1, pc_source=00; next DECODE.
REQ-014 DECODE: alu_src_b=11, alu_op=00; next state by opcode:
  - 100011 (LW) or 101011 (SW) -> MEM_ADDR
  - 000000 (R-type) -> EXECUTE
  - 000100 (BEQ) -> BRANCH
  - 000010 (J) -> JUMP
  - any other opcode -> FETCH, with illegal_op=1 for that DECODE cycle.
REQ-015 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEM_READ for LW, MEM_WRITE for SW.
REQ-016 MEM_READ: mem_read=1, i_or_d=1; next MEM_WB.
REQ-017 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-018 MEM_WRITE: mem_write=1, i_or_d=1; next FETCH.
REQ-019 EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10; next R_WB.
REQ-020 R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; next FETCH.
REQ-021 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; next FETCH.
REQ-022 JUMP: pc_write=1, pc_source=10; next FETCH.
REQ-023 Any output not listed for a state SHALL be 0.
REQ-024 Cycles per instruction, without wait states: LW 5, SW 4, R-type 4, BEQ 3, J 3, illegal 2.
REQ-025 An unreachable state encoding SHALL go to FETCH on the next edge; all outputs are 0 while in it.

Reset
REQ-026 While rst_n=0 at a rising edge, state SHALL become FETCH and every output SHALL be 0, overriding the state decode.
REQ-027 The first clock edge with rst_n=1 SHALL execute FETCH; outputs take their FETCH values in the cycle after reset deasserts.
REQ-028 Reset asserted in any state, including mid-instruction, SHALL abort the instruction with no further strobes.

Configuration
REQ-029 Macro MEM_WAIT_EN.
  - Defined: FETCH, MEM_READ and MEM_WRITE SHALL hold, with outputs unchanged, until a cycle in which mem_ready=1.
  - Defined: pc_write and ir_write in FETCH SHALL assert only in the cycle in which mem_ready=1.
  - Not defined: mem_ready SHALL be ignored and every state lasts exactly one cycle.

Structure
REQ-030 Shared package ctl_pkg SHALL hold the opcode constants, the state enum typedef, and the alu_op and alu_src_b/pc_source encodings.
REQ-031 The state register and next-state logic and the output decode SHALL be in one module; no sub-module.

Verification
REQ-032 Reset: hold rst_n=0 for 3 cycles in the middle of EXECUTE -> all outputs 0; after release state=FETCH, then FETCH outputs (pc_write=1, ir_write=1).
REQ-033 LW: opcode=100011 -> state sequence FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB; reg_write=1 and mem_to_reg=1 in cycle 5.
REQ-034 R-type then BEQ back-to-back: opcode=000000 then 000100 -> alu_op 10 in EXECUTE, then 01 in BRANCH with pc_write_cond=1; 7 cycles total.
REQ-035 Illegal opcode=111111 -> illegal_op=1 for exactly one cycle in DECODE, then FETCH; no reg_write or mem_write is asserted.
REQ-036 With MEM_WAIT_EN defined: SW with mem_ready=0 for 3 cycles in MEM_WRITE -> mem_write=1 for 4 cycles, then FETCH.
REQ-037 J: opcode=000010 -> pc_write=1 and pc_source=10 in cycle 3, then FETCH.
